lrf_stream_sequencer: RTL and testbench

Parametrised AXI-Stream frame sequencer for the lucky-region-fusion (LRF) pipeline. Sits between the input/output streams and the fusion datapath (HSSIM + fusion + frame LSUs). It accepts raw frames, generates per-beat addresses and frame-window control for the datapath, and realigns the datapath result with valid/last after a fixed latency. It emits fused frames in block mode (one per FUSE_COUNT frames) or sliding mode (every frame after warm-up), with full output backpressure and tlast checking.

---
 rtl/lrf_pkg.sv | 22 ++
 rtl/lrf_delay_line.sv | 29 ++
 rtl/lrf_stream_sequencer.sv | 115 +++++++++++
 tb/tb_lrf_stream_sequencer.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lrf_pkg.sv
// Shared types and sizing helpers for the LRF stream sequencer.
// Frame geometry is derived here so the top and any sub-module agree on counter widths.
package lrf_pkg;

    localparam int MODE_BLOCK   = 0;
    localparam int MODE_SLIDING = 1;

    function automatic int beats_of(input int image_dim, input int pixels_per_beat);
        return image_dim * image_dim / pixels_per_beat;
    endfunction

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    typedef struct packed {
        logic valid;
        logic last;
        logic emit;
    } dl_entry_t;

endpackage

// File: rtl/lrf_delay_line.sv
// Clock-enabled shift register with asynchronous clear.
// It tracks beat control bits alongside the fusion datapath so results can be realigned.
module lrf_delay_line #(
    parameter int WIDTH = 3,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ce,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stages [DEPTH];

    // NOTE: this storage is reset on purpose; a reset must flush in-flight beats,
    // so the usual rule of leaving data arrays unreset does not apply here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) stages[i] <= '0;
        end else if (ce) begin
            stages[0] <= d;
            for (int i = 1; i < DEPTH; i++) stages[i] <= stages[i-1];
        end
    end

    assign q = stages[DEPTH-1];

endmodule

// File: rtl/lrf_stream_sequencer.sv
// Frame sequencer for the lucky-region-fusion pipeline: beat/frame counters,
// datapath stall control, and realignment of datapath results onto the output stream.
module lrf_stream_sequencer
    import lrf_pkg::*;
#(
    parameter int PIXELS_PER_BEAT = 16,
    parameter int IMAGE_DIM       = 512,
    parameter int FUSE_COUNT      = 16,
    parameter int MODE            = MODE_BLOCK,
    parameter int DP_LATENCY      = 4,
    parameter int DATA_WIDTH      = 8 * PIXELS_PER_BEAT
) (
    input  logic                  s_axis_aclk,
    input  logic                  s_axis_aresetn,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    input  logic                  s_axis_tlast,
    output logic                  s_axis_tready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    output logic                  m_axis_tlast,
    input  logic                  m_axis_tready,
    output logic                  dp_ce,
    output logic                  dp_in_valid,
    output logic [cnt_width(beats_of(IMAGE_DIM, PIXELS_PER_BEAT))-1:0] beat_addr,
    output logic [cnt_width(FUSE_COUNT)-1:0] frame_idx,
    output logic                  first_frame,
    output logic                  window_full,
    input  logic [DATA_WIDTH-1:0] dp_out_data,
    output logic                  err_tlast
);

    localparam int BEATS = beats_of(IMAGE_DIM, PIXELS_PER_BEAT);
    localparam int AW    = cnt_width(BEATS);
    localparam int FW    = cnt_width(FUSE_COUNT);
    localparam logic [AW-1:0] LAST_BEAT  = AW'(BEATS - 1);
    localparam logic [FW-1:0] LAST_FRAME = FW'(FUSE_COUNT - 1);

    logic      rst_done;
    logic      accept;
    logic      at_last_beat;
    logic      frame_end;
    logic      emit;
    logic      unused_tdata;
    dl_entry_t dl_head;
    dl_entry_t dl_tail;

    // Pixel data flows straight into the datapath; only its handshake is sequenced here.
    assign unused_tdata = ^s_axis_tdata;

    assign dp_ce         = ~m_axis_tvalid | m_axis_tready;
    assign s_axis_tready = rst_done & dp_ce;
    assign accept        = s_axis_tvalid & s_axis_tready;
    assign dp_in_valid   = accept;
    assign at_last_beat  = (beat_addr == LAST_BEAT);
    assign frame_end     = at_last_beat | s_axis_tlast;
    assign emit          = (MODE == MODE_SLIDING) ? (window_full | (frame_idx == LAST_FRAME))
                                                  : (frame_idx == LAST_FRAME);

    assign dl_head.valid = accept;
    assign dl_head.last  = frame_end;
    assign dl_head.emit  = emit;

    always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
        if (!s_axis_aresetn) begin
            rst_done    <= 1'b0;
            beat_addr   <= '0;
            frame_idx   <= '0;
            first_frame <= 1'b1;
            window_full <= 1'b0;
            err_tlast   <= 1'b0;
        end else begin
            rst_done <= 1'b1;
            if (accept) begin
                // An early tlast or a missing one both flag; the frame ends on whichever comes first.
                if (s_axis_tlast != at_last_beat) err_tlast <= 1'b1;
                if (frame_end) begin
                    beat_addr   <= '0;
                    frame_idx   <= (frame_idx == LAST_FRAME) ? '0 : frame_idx + 1'b1;
                    first_frame <= 1'b0;
                    if (frame_idx == LAST_FRAME) window_full <= 1'b1;
                end else begin
                    beat_addr <= beat_addr + 1'b1;
                end
            end
        end
    end

    lrf_delay_line #(
        .WIDTH($bits(dl_entry_t)),
        .DEPTH(DP_LATENCY)
    ) u_delay_line (
        .clk  (s_axis_aclk),
        .rst_n(s_axis_aresetn),
        .ce   (dp_ce),
        .d    (dl_head),
        .q    (dl_tail)
    );

    // A load while the sink accepts keeps tvalid high, giving one beat per cycle.
    always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
        if (!s_axis_aresetn) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            m_axis_tdata  <= '0;
        end else if (dp_ce && dl_tail.valid && dl_tail.emit) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tlast  <= dl_tail.last;
            m_axis_tdata  <= dp_out_data;
        end else if (m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_lrf_stream_sequencer.sv
// Directed bench for lrf_stream_sequencer: one block-mode and one sliding-mode instance
// driven from shared stimulus, with a 3-cycle enabled delay standing in for the datapath.
module tb_lrf_stream_sequencer;

    localparam int PPB = 16;
    localparam int DIM = 8;
    localparam int FC  = 4;
    localparam int LAT = 3;
    localparam int DW  = 8 * PPB;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic [DW-1:0] s_tdata;
    logic          s_tvalid;
    logic          s_tlast;
    logic          m_tready;
    logic          sel;
    bit            tog_en;
    bit            tog_phase;

    logic          s_tready_0, m_tvalid_0, m_tlast_0, dp_ce_0, dp_in_valid_0;
    logic          first_frame_0, window_full_0, err_tlast_0;
    logic [DW-1:0] m_tdata_0, dp_out_0;
    logic [1:0]    beat_addr_0, frame_idx_0;
    logic          s_tready_1, m_tvalid_1, m_tlast_1, dp_ce_1, dp_in_valid_1;
    logic          first_frame_1, window_full_1, err_tlast_1;
    logic [DW-1:0] m_tdata_1, dp_out_1;
    logic [1:0]    beat_addr_1, frame_idx_1;

    logic [DW-1:0] p0 [3];
    logic [DW-1:0] p1 [3];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    lrf_stream_sequencer #(
        .PIXELS_PER_BEAT(PPB), .IMAGE_DIM(DIM), .FUSE_COUNT(FC), .MODE(0), .DP_LATENCY(LAT)
    ) dut0 (
        .s_axis_aclk(clk), .s_axis_aresetn(rst_n), .s_axis_tdata(s_tdata),
        .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast), .s_axis_tready(s_tready_0),
        .m_axis_tdata(m_tdata_0), .m_axis_tvalid(m_tvalid_0), .m_axis_tlast(m_tlast_0),
        .m_axis_tready(m_tready), .dp_ce(dp_ce_0), .dp_in_valid(dp_in_valid_0),
        .beat_addr(beat_addr_0), .frame_idx(frame_idx_0), .first_frame(first_frame_0),
        .window_full(window_full_0), .dp_out_data(dp_out_0), .err_tlast(err_tlast_0)
    );

    lrf_stream_sequencer #(
        .PIXELS_PER_BEAT(PPB), .IMAGE_DIM(DIM), .FUSE_COUNT(FC), .MODE(1), .DP_LATENCY(LAT)
    ) dut1 (
        .s_axis_aclk(clk), .s_axis_aresetn(rst_n), .s_axis_tdata(s_tdata),
        .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast), .s_axis_tready(s_tready_1),
        .m_axis_tdata(m_tdata_1), .m_axis_tvalid(m_tvalid_1), .m_axis_tlast(m_tlast_1),
        .m_axis_tready(m_tready), .dp_ce(dp_ce_1), .dp_in_valid(dp_in_valid_1),
        .beat_addr(beat_addr_1), .frame_idx(frame_idx_1), .first_frame(first_frame_1),
        .window_full(window_full_1), .dp_out_data(dp_out_1), .err_tlast(err_tlast_1)
    );

    // Datapath stand-in: input data delayed LAT enabled cycles, independently per instance.
    always @(posedge clk) begin
        if (dp_ce_0) begin p0[2] <= p0[1]; p0[1] <= p0[0]; p0[0] <= s_tdata; end
        if (dp_ce_1) begin p1[2] <= p1[1]; p1[1] <= p1[0]; p1[0] <= s_tdata; end
    end
    assign dp_out_0 = p0[2];
    assign dp_out_1 = p1[2];

    logic          s_tready, m_tvalid, m_tlast, dp_in_valid, first_frame, window_full, err_tlast;
    logic [DW-1:0] m_tdata;
    logic [1:0]    beat_addr, frame_idx;
    assign s_tready    = sel ? s_tready_1    : s_tready_0;
    assign m_tvalid    = sel ? m_tvalid_1    : m_tvalid_0;
    assign m_tlast     = sel ? m_tlast_1     : m_tlast_0;
    assign m_tdata     = sel ? m_tdata_1     : m_tdata_0;
    assign dp_in_valid = sel ? dp_in_valid_1 : dp_in_valid_0;
    assign first_frame = sel ? first_frame_1 : first_frame_0;
    assign window_full = sel ? window_full_1 : window_full_0;
    assign err_tlast   = sel ? err_tlast_1   : err_tlast_0;
    assign beat_addr   = sel ? beat_addr_1   : beat_addr_0;
    assign frame_idx   = sel ? frame_idx_1   : frame_idx_0;

    assign m_tready = tog_en ? tog_phase : 1'b1;
    always @(posedge clk) begin
        cyc++;
        #1 tog_phase = ~tog_phase;
    end

    logic [DW:0] out_q[$];
    int          out_cyc[$];
    int          acc_cyc[$];
    logic [1:0]  obs_ba[$];
    logic [1:0]  obs_fi[$];
    logic        obs_ff[$];
    logic        obs_wf[$];

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (m_tvalid && m_tready) begin
                out_q.push_back({m_tlast, m_tdata});
                out_cyc.push_back(cyc);
            end
            if (dp_in_valid) acc_cyc.push_back(cyc);
        end
    end

    bit          bp_en;
    int          bp_viol = 0;
    int          bp_stalls = 0;
    logic        prev_stall = 1'b0;
    logic [DW:0] prev_beat;
    always @(negedge clk) begin
        if (bp_en) begin
            if (s_tready !== !(m_tvalid && !m_tready)) bp_viol++;
            if (prev_stall && (m_tvalid !== 1'b1 || {m_tlast, m_tdata} !== prev_beat)) bp_viol++;
            if (m_tvalid && !m_tready) bp_stalls++;
            prev_stall = m_tvalid && !m_tready;
            prev_beat  = {m_tlast, m_tdata};
        end else begin
            prev_stall = 1'b0;
        end
    end

    function automatic logic [DW-1:0] mk(input int f, input int b);
        return {96'd0, 16'hA5A5, f[7:0], b[7:0]};
    endfunction

    task automatic clear_logs();
        out_q.delete(); out_cyc.delete(); acc_cyc.delete();
        obs_ba.delete(); obs_fi.delete(); obs_ff.delete(); obs_wf.delete();
    endtask

    task automatic do_reset(input logic s);
        sel = s; tog_en = 0; s_tvalid = 0; s_tlast = 0; s_tdata = '0;
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        @(posedge clk); #1;
        clear_logs();
    endtask

    task automatic send_beat(input logic [DW-1:0] d, input logic l);
        bit acc = 0;
        s_tvalid = 1; s_tdata = d; s_tlast = l;
        for (int i = 0; i < 64 && !acc; i++) begin
            @(negedge clk);
            if (s_tready === 1'b1) begin
                acc = 1;
                obs_ba.push_back(beat_addr); obs_fi.push_back(frame_idx);
                obs_ff.push_back(first_frame); obs_wf.push_back(window_full);
            end
            @(posedge clk); #1;
        end
        s_tvalid = 0; s_tlast = 0;
        if (!acc) begin
            $display("FAIL send_beat: s_axis_tready got 0 for 64 cycles, expected 1");
            failures++; checks++;
        end
    endtask

    task automatic send_frame(input int f, input int n, input int tlast_at);
        for (int b = 0; b < n; b++) send_beat(mk(f, b), (b == tlast_at));
    endtask

    task automatic test_reset();
        sel = 0; tog_en = 0; s_tvalid = 0; s_tlast = 0; s_tdata = '0;
        rst_n = 0;
        @(posedge clk); #1;
        if (m_tvalid !== 1'b0) begin $display("FAIL rst_tvalid: got %b expected 0", m_tvalid); failures++; end
        checks++;
        if ({m_tlast, m_tdata} !== '0) begin $display("FAIL rst_tdata: got %h expected 0", {m_tlast, m_tdata}); failures++; end
        checks++;
        if (s_tready !== 1'b0) begin $display("FAIL rst_tready: got %b expected 0", s_tready); failures++; end
        checks++;
        if ({beat_addr, frame_idx} !== 4'd0) begin $display("FAIL rst_counters: got %h expected 0", {beat_addr, frame_idx}); failures++; end
        checks++;
        if ({first_frame, window_full, err_tlast} !== 3'b100) begin
            $display("FAIL rst_flags: got %b expected 100", {first_frame, window_full, err_tlast}); failures++;
        end
        checks++;
        #1 rst_n = 1;
        @(negedge clk);
        if (s_tready !== 1'b0) begin $display("FAIL rst_release_tready: got %b expected 0", s_tready); failures++; end
        checks++;
        @(posedge clk); #1;
        if (s_tready !== 1'b1) begin $display("FAIL rst_done_tready: got %b expected 1", s_tready); failures++; end
        checks++;
    endtask

    task automatic test_block_mode();
        int lat;
        logic [DW:0] exp_beat;
        do_reset(0);
        for (int f = 0; f < 8; f++) send_frame(f, 4, 3);
        repeat (10) @(posedge clk); #1;
        if (out_q.size() != 8) begin $display("FAIL block_count: got %0d expected 8", out_q.size()); failures++; end
        checks++;
        for (int i = 0; i < 8 && i < out_q.size(); i++) begin
            exp_beat = {(i % 4 == 3), mk((i < 4) ? 3 : 7, i % 4)};
            if (out_q[i] !== exp_beat) begin
                $display("FAIL block_beat%0d: got %h expected %h", i, out_q[i], exp_beat); failures++;
            end
            checks++;
        end
        lat = (acc_cyc.size() > 12 && out_cyc.size() > 0) ? out_cyc[0] - acc_cyc[12] : -1;
        if (lat != LAT + 1) begin $display("FAIL block_latency: got %0d expected %0d", lat, LAT + 1); failures++; end
        checks++;
        if (obs_fi.size() < 13 || obs_fi[12] !== 2'd3) begin $display("FAIL block_frame3_idx: frame index of beat 12 not 3"); failures++; end
        checks++;
        if ({first_frame, window_full, err_tlast} !== 3'b010) begin
            $display("FAIL block_flags: got %b expected 010", {first_frame, window_full, err_tlast}); failures++;
        end
        checks++;
    endtask

    task automatic test_sliding_mode();
        logic [DW:0] exp_beat;
        do_reset(1);
        for (int f = 0; f < 6; f++) send_frame(f, 4, 3);
        repeat (10) @(posedge clk); #1;
        if (out_q.size() != 12) begin $display("FAIL slide_count: got %0d expected 12", out_q.size()); failures++; end
        checks++;
        for (int i = 0; i < 12 && i < out_q.size(); i++) begin
            exp_beat = {(i % 4 == 3), mk(3 + i / 4, i % 4)};
            if (out_q[i] !== exp_beat) begin
                $display("FAIL slide_beat%0d: got %h expected %h", i, out_q[i], exp_beat); failures++;
            end
            checks++;
        end
        if (obs_wf.size() < 17 || {obs_wf[15], obs_wf[16]} !== 2'b01) begin
            $display("FAIL slide_window_full: window_full around beat 15 not 0 then 1"); failures++;
        end
        checks++;
        if (obs_ff.size() < 5 || {obs_ff[3], obs_ff[4]} !== 2'b10) begin
            $display("FAIL slide_first_frame: first_frame around beat 3 not 1 then 0"); failures++;
        end
        checks++;
    endtask

    task automatic test_backpressure();
        logic [DW:0] exp_beat;
        do_reset(1);
        bp_en = 1; tog_en = 1;
        for (int f = 0; f < 6; f++) send_frame(f, 4, 3);
        repeat (60) @(posedge clk); #1;
        bp_en = 0; tog_en = 0;
        if (out_q.size() != 12) begin $display("FAIL bp_count: got %0d expected 12", out_q.size()); failures++; end
        checks++;
        for (int i = 0; i < 12 && i < out_q.size(); i++) begin
            exp_beat = {(i % 4 == 3), mk(3 + i / 4, i % 4)};
            if (out_q[i] !== exp_beat) begin
                $display("FAIL bp_beat%0d: got %h expected %h", i, out_q[i], exp_beat); failures++;
            end
            checks++;
        end
        if (bp_viol != 0) begin $display("FAIL bp_stall_rules: got %0d violations expected 0", bp_viol); failures++; end
        checks++;
        if (bp_stalls == 0) begin $display("FAIL bp_stall_seen: got 0 stall cycles expected >0"); failures++; end
        checks++;
    endtask

    task automatic test_tlast_errors();
        do_reset(0);
        send_frame(0, 4, 3);
        if (err_tlast !== 1'b0) begin $display("FAIL tlast_clean: got %b expected 0", err_tlast); failures++; end
        checks++;
        send_frame(1, 3, 2);
        if (err_tlast !== 1'b1) begin $display("FAIL tlast_early: got %b expected 1", err_tlast); failures++; end
        checks++;
        send_frame(2, 4, 3);
        if (obs_ba.size() < 8 || {obs_ba[7], obs_fi[7]} !== 4'b0010) begin
            $display("FAIL tlast_early_next: beat after early tlast not beat 0 of frame 2"); failures++;
        end
        checks++;
        do_reset(0);
        if (err_tlast !== 1'b0) begin $display("FAIL tlast_reset_clear: got %b expected 0", err_tlast); failures++; end
        checks++;
        send_frame(0, 4, -1);
        if (err_tlast !== 1'b1) begin $display("FAIL tlast_missing: got %b expected 1", err_tlast); failures++; end
        checks++;
        send_beat(mk(1, 0), 1'b0);
        if (obs_ba.size() < 5 || {obs_ba[4], obs_fi[4]} !== 4'b0001) begin
            $display("FAIL tlast_missing_next: beat after missing tlast not beat 0 of frame 1"); failures++;
        end
        checks++;
    endtask

    task automatic test_reset_midframe();
        do_reset(1);
        for (int f = 0; f < 6; f++) send_frame(f, 4, 3);
        send_frame(6, 2, -1);
        if (m_tvalid !== 1'b1) begin $display("FAIL mid_pre_tvalid: got %b expected 1", m_tvalid); failures++; end
        checks++;
        rst_n = 0;
        #1;
        if ({m_tvalid, s_tready} !== 2'b00) begin
            $display("FAIL mid_async: tvalid,tready got %b expected 00", {m_tvalid, s_tready}); failures++;
        end
        checks++;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        clear_logs();
        @(negedge clk);
        if (s_tready !== 1'b0) begin $display("FAIL mid_release_tready: got %b expected 0", s_tready); failures++; end
        checks++;
        repeat (8) @(posedge clk); #1;
        if (out_q.size() != 0 || m_tvalid !== 1'b0) begin
            $display("FAIL mid_stale: got %0d output beats expected 0", out_q.size()); failures++;
        end
        checks++;
        send_beat(mk(0, 0), 1'b0);
        if (obs_fi.size() < 1 || {obs_ba[0], obs_fi[0], obs_ff[0], obs_wf[0]} !== 6'b000010) begin
            $display("FAIL mid_restart: first beat after reset not beat 0 of frame 0 with first_frame"); failures++;
        end
        checks++;
    endtask

    initial begin
        test_reset();
        test_block_mode();
        test_sliding_mode();
        test_backpressure();
        test_tlast_errors();
        test_reset_midframe();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1, "watchdog");
    end

endmodule
